// File: rtl/instr_cache.sv
// instr_cache: direct-mapped read-only instruction cache with same-cycle hits and beat-wise line refill
module instr_cache #(
    parameter int N_Bits         = 32,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_Bits-1:0] A,
    input  logic              fetch_en,
    input  logic              flush,
    output logic [N_Bits-1:0] RD,
    output logic              stall,
    output logic              mem_req,
    output logic [N_Bits-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [N_Bits-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = N_Bits - 2 - OFF_W - IDX_W;

    typedef enum logic {IDLE, REFILL} state_e;

    state_e                  state_q, state_d;
    logic [OFF_W-1:0]        beat_q, beat_d;
    logic [N_Bits-1:0]       base_q, base_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic [CNT_W-1:0]        hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic [N_Bits-1:0]       data_q [LINES*WORDS_PER_LINE];
    logic [TAG_W-1:0]        tag_q [LINES];

    logic [IDX_W-1:0]        idx, r_idx;
    logic [OFF_W-1:0]        off;
    logic [TAG_W-1:0]        a_tag, r_tag;
    logic                    hit, miss, wr, unused_a;

    assign idx      = A[2+OFF_W +: IDX_W];
    assign off      = A[2 +: OFF_W];
    assign a_tag    = A[N_Bits-1 -: TAG_W];
    assign r_idx    = base_q[2+OFF_W +: IDX_W];
    assign r_tag    = base_q[N_Bits-1 -: TAG_W];
    assign unused_a = ^A[1:0];

    assign hit  = state_q == IDLE && fetch_en && !flush && valid_q[idx] && tag_q[idx] == a_tag;
    assign miss = state_q == IDLE && fetch_en && !flush && !hit;
    assign wr   = state_q == REFILL && mem_ack && !flush;

    assign RD         = hit ? data_q[{idx, off}] : '0;
    assign stall      = state_q == REFILL || (fetch_en && !hit);
    assign mem_req    = state_q == REFILL;
    assign mem_addr   = mem_req ? base_q | (N_Bits'(beat_q) << 2) : '0;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    // Next state: start refill on a miss, advance beats on ack, abort on flush
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        base_d     = base_q;
        valid_d    = flush ? '0 : valid_q;
        hit_cnt_d  = (hit && ~&hit_cnt_q) ? hit_cnt_q + 1'b1 : hit_cnt_q;
        miss_cnt_d = (miss && ~&miss_cnt_q) ? miss_cnt_q + 1'b1 : miss_cnt_q;
        if (miss) begin
            state_d = REFILL;
            beat_d  = '0;
            base_d  = {A[N_Bits-1:2+OFF_W], {(2+OFF_W){1'b0}}};
        end
        if (state_q == REFILL) begin
            if (flush) begin
                state_d = IDLE;
                beat_d  = '0;
            end else if (mem_ack) begin
                beat_d = beat_q + 1'b1;
                if (&beat_q) begin
                    state_d        = IDLE;
                    valid_d[r_idx] = 1'b1;
                end
            end
        end
    end

    // Control state, valid bits and counters; reset takes effect immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            base_q     <= '0;
            valid_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            base_q     <= base_d;
            valid_q    <= valid_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Data and tag arrays hold no reset; validity is tracked by valid_q alone
    always_ff @(posedge clk) begin
        if (wr) data_q[{r_idx, beat_q}] <= mem_rdata;
        if (wr && &beat_q) tag_q[r_idx] <= r_tag;
    end
endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: directed scoreboard bench for instr_cache
module tb_instr_cache;
    logic        clk = 0, rst = 1, fetch_en = 0, flush = 0, mem_ack, stall, mem_req;
    logic [31:0] A = 0, RD, mem_addr, mem_rdata;
    logic [3:0]  hit_count, miss_count;

    instr_cache #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .A(A), .fetch_en(fetch_en), .flush(flush),
        .RD(RD), .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Backing memory: word at byte address a holds a*0x11; ack every wait_n-th request cycle
    int wait_n = 1, wait_cnt = 0;
    always @(posedge clk) wait_cnt <= (!mem_req || wait_cnt == wait_n - 1) ? 0 : wait_cnt + 1;
    assign mem_ack   = mem_req && wait_cnt == wait_n - 1;
    assign mem_rdata = mem_addr * 32'h11;

    typedef enum {S_STALL, S_REQ, S_ADDR, S_RD, S_HIT, S_MISS} sel_e;
    typedef struct {sel_e sel; logic [31:0] exp; string name;} chk_t;
    chk_t        chk_q[$];
    logic [31:0] rd_q[$];
    int          vectors = 0, miscompares = 0;
    bit          done = 0;
    chk_t        c;
    logic [31:0] got, exp_rd;

    task automatic step(input logic [31:0] a, input logic fe, input logic fl);
        @(posedge clk);
        #1;
        A = a; fetch_en = fe; flush = fl;
    endtask

    task automatic want(input sel_e s, input logic [31:0] e, input string n);
        chk_q.push_back('{s, e, n});
    endtask

    task automatic hit(input logic [31:0] a, input logic [31:0] e);
        step(a, 1, 0);
        rd_q.push_back(e);
        want(S_STALL, 0, "hit_stall");
    endtask

    task automatic fill(input logic [31:0] a, input logic [31:0] misses);
        step(a, 1, 0);
        want(S_STALL, 1, "miss_stall");
        want(S_REQ, 0, "miss_req");
        for (int i = 0; i < 4; i++) begin
            step(a, 1, 0);
            want(S_REQ, 1, "refill_req");
            want(S_ADDR, (a & ~32'hF) + 4 * i, "refill_addr");
            want(S_STALL, 1, "refill_stall");
        end
        hit(a, a * 32'h11);
        want(S_MISS, misses, "miss_count");
    endtask

    // Monitor: evaluate queued checks and compare every presented instruction
    always @(negedge clk) begin
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            case (c.sel)
                S_STALL: got = 32'(stall);
                S_REQ:   got = 32'(mem_req);
                S_ADDR:  got = mem_addr;
                S_RD:    got = RD;
                S_HIT:   got = 32'(hit_count);
                default: got = 32'(miss_count);
            endcase
            vectors++;
            if (got !== c.exp) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", c.name, got, c.exp);
            end
        end
        if (fetch_en && !stall) begin
            vectors++;
            if (rd_q.size() == 0) begin
                miscompares++;
                $display("FAIL rd_unexpected: got %h expected no instruction", RD);
            end else begin
                exp_rd = rd_q.pop_front();
                if (RD !== exp_rd) begin
                    miscompares++;
                    $display("FAIL rd: got %h expected %h (A=%h)", RD, exp_rd, A);
                end
            end
        end
        if (done) begin
            vectors++;
            if (rd_q.size() != 0) begin
                miscompares++;
                $display("FAIL rd_pending: got %0d outstanding expected 0", rd_q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    initial begin
        step(0, 1, 0);
        want(S_STALL, 1, "rst_stall");
        want(S_RD, 0, "rst_rd");
        want(S_REQ, 0, "rst_req");
        want(S_ADDR, 0, "rst_addr");
        want(S_HIT, 0, "rst_hits");
        want(S_MISS, 0, "rst_misses");
        step(0, 0, 0);
        rst = 0;
        // cold miss, zero wait, then hits within the line
        fill(0, 1);
        hit(32'h4, 32'h44);
        hit(32'h8, 32'h88);
        hit(32'hC, 32'hCC);
        step(0, 0, 0);
        want(S_RD, 0, "idle_rd");
        want(S_STALL, 0, "idle_stall");
        want(S_REQ, 0, "idle_req");
        want(S_ADDR, 0, "idle_addr");
        want(S_HIT, 4, "hit_count");
        // wait states: ack on every third cycle
        wait_n = 3;
        step(32'h40, 1, 0);
        want(S_STALL, 1, "wait_miss_stall");
        for (int b = 0; b < 4; b++)
            for (int w = 0; w < 3; w++) begin
                step(32'h40, 1, 0);
                want(S_ADDR, 32'h40 + 4 * b, "wait_addr");
                want(S_STALL, 1, "wait_stall");
            end
        hit(32'h40, 32'h440);
        want(S_MISS, 2, "wait_misses");
        step(0, 0, 0);
        wait_n = 1;
        // conflict eviction on index 0
        hit(0, 0);
        fill(32'h100, 3);
        fill(0, 4);
        // flush in idle
        fill(32'h10, 5);
        step(32'h10, 1, 1);
        want(S_STALL, 1, "flush_stall");
        want(S_HIT, 9, "flush_hits");
        want(S_MISS, 5, "flush_misses");
        fill(0, 6);
        // flush during beat 2 aborts the refill
        step(32'h20, 1, 0);
        want(S_STALL, 1, "abort_miss_stall");
        step(32'h20, 1, 0);
        want(S_ADDR, 32'h20, "abort_b0");
        step(32'h20, 1, 0);
        want(S_ADDR, 32'h24, "abort_b1");
        step(32'h20, 1, 1);
        want(S_ADDR, 32'h28, "abort_b2");
        want(S_REQ, 1, "abort_req");
        fill(32'h20, 8);
        // asynchronous reset during beat 1
        step(32'h30, 1, 0);
        want(S_MISS, 8, "pre_rst_misses");
        step(32'h30, 1, 0);
        want(S_ADDR, 32'h30, "rst_b0");
        step(32'h30, 1, 0);
        rst = 1;
        want(S_REQ, 0, "midrst_req");
        want(S_ADDR, 0, "midrst_addr");
        want(S_HIT, 0, "midrst_hits");
        want(S_MISS, 0, "midrst_misses");
        want(S_STALL, 1, "midrst_stall");
        want(S_RD, 0, "midrst_rd");
        step(32'h30, 0, 0);
        rst = 0;
        fill(32'h30, 1);
        // hit counter saturation at 15 after 20 hits
        for (int i = 0; i < 19; i++) hit(32'h30, 32'h330);
        step(0, 0, 0);
        want(S_HIT, 15, "hit_sat");
        want(S_MISS, 1, "sat_misses");
        step(0, 0, 0);
        done = 1;
    end
endmodule
